// File: rtl/i2c_pkg.sv
// Shared types and constants for the byte-oriented I2C master.
// Covers the state encoding, quarter-phase names and bit-counter width.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_AACK,
        ST_WR,
        ST_WACK,
        ST_RD,
        ST_RNACK,
        ST_STOP
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic I2C_NACK = 1'b1;

    localparam int BIT_W = 4;

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-SCL-period tick generator with synchronous clear and clock-stretch hold.
// qtick pulses for one cycle every CLK_DIV enabled, un-held cycles.
module i2c_qtick #(
    parameter int CLK_DIV = 125
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic hold,
    output logic qtick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Holding at zero means a stretched quarter restarts its full length once SCL is seen high
    always_ff @(posedge clk) begin
        if (reset || clear || !en || hold) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign qtick = en && !hold && (cnt == LAST);

endmodule

// File: rtl/i2c_master_byte.sv
// Single-master I2C controller: START, address+R/W, one data byte (write, or read+NACK), STOP.
// SCL/SDA are open-drain drives (0 = pull low) taken directly from flops.
module i2c_master_byte
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_o,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    state_t           state;
    logic [1:0]       phase;
    logic [BIT_W-1:0] bitcnt;
    logic [7:0]       tx_sr;
    logic [7:0]       rx_sr;
    logic [7:0]       wdata_r;
    logic             rw_r;
    logic             sda_smp;
    logic             qtick;
    logic             accept;
    logic             hold;

    assign accept = (state == ST_IDLE) && start;
    // A responder stretches by holding SCL low while we have released it
    assign hold   = scl_o && !scl_i;

    i2c_qtick #(
        .CLK_DIV (CLK_DIV)
    ) u_qtick (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .en    (busy),
        .hold  (hold),
        .qtick (qtick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            phase   <= Q0;
            bitcnt  <= '0;
            scl_o   <= 1'b1;
            sda_o   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            rdata   <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    tx_sr   <= {addr, rw};
                    wdata_r <= wdata;
                    rw_r    <= rw;
                    ack_err <= 1'b0;
                    busy    <= 1'b1;
                    state   <= ST_START;
                    phase   <= Q0;
                    bitcnt  <= '0;
                    scl_o   <= 1'b1;
                    sda_o   <= 1'b1;
                end
            end else if (qtick) begin
                case (state)
                    ST_START: begin
                        if (phase == Q0) begin
                            phase <= Q1;
                            sda_o <= 1'b0;
                        end else begin
                            state <= ST_ADDR;
                            phase <= Q0;
                            scl_o <= 1'b0;
                            sda_o <= tx_sr[7];
                        end
                    end
                    ST_STOP: begin
                        case (phase)
                            Q0: begin
                                phase <= Q1;
                                scl_o <= 1'b1;
                            end
                            Q1: begin
                                phase <= Q2;
                                sda_o <= 1'b1;
                            end
                            default: begin
                                state <= ST_IDLE;
                                phase <= Q0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                    default: begin
                        // Bit cell: SDA only moves on the Q3->Q0 boundary, while SCL is low
                        case (phase)
                            Q0: phase <= Q1;
                            Q1: begin
                                phase <= Q2;
                                scl_o <= 1'b1;
                            end
                            Q2: begin
                                phase   <= Q3;
                                sda_smp <= sda_i;
                                if (state == ST_RD) begin
                                    rx_sr <= {rx_sr[6:0], sda_i};
                                end
                            end
                            default: begin
                                phase <= Q0;
                                scl_o <= 1'b0;
                                case (state)
                                    ST_ADDR, ST_WR: begin
                                        tx_sr <= {tx_sr[6:0], 1'b0};
                                        if (bitcnt == BIT_W'(7)) begin
                                            state <= (state == ST_ADDR) ? ST_AACK : ST_WACK;
                                            sda_o <= 1'b1;
                                        end else begin
                                            bitcnt <= bitcnt + BIT_W'(1);
                                            sda_o  <= tx_sr[6];
                                        end
                                    end
                                    ST_AACK: begin
                                        bitcnt <= '0;
                                        if (sda_smp) begin
                                            ack_err <= 1'b1;
                                            state   <= ST_STOP;
                                            sda_o   <= 1'b0;
                                        end else if (rw_r) begin
                                            state <= ST_RD;
                                            sda_o <= 1'b1;
                                        end else begin
                                            state <= ST_WR;
                                            tx_sr <= wdata_r;
                                            sda_o <= wdata_r[7];
                                        end
                                    end
                                    ST_WACK: begin
                                        state <= ST_STOP;
                                        sda_o <= 1'b0;
                                        if (sda_smp) begin
                                            ack_err <= 1'b1;
                                        end
                                    end
                                    ST_RD: begin
                                        if (bitcnt == BIT_W'(7)) begin
                                            state <= ST_RNACK;
                                            sda_o <= I2C_NACK;
                                        end else begin
                                            bitcnt <= bitcnt + BIT_W'(1);
                                            sda_o  <= 1'b1;
                                        end
                                    end
                                    ST_RNACK: begin
                                        rdata <= rx_sr;
                                        state <= ST_STOP;
                                        sda_o <= 1'b0;
                                    end
                                    default: state <= ST_IDLE;
                                endcase
                            end
                        endcase
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Directed bench for i2c_master_byte with a behavioural responder and bus monitor.
// Each task drives one scenario and checks bus bits, timing and status against hand-computed values.
module tb_i2c_master_byte;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] addr = 7'h00;
    logic       rw = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       scl_i, sda_i, scl_o, sda_o, busy, done, ack_err;
    logic [7:0] rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;

    logic       resp_sda = 1'b1;
    logic       resp_ack = 1'b1;
    logic       resp_read = 1'b0;
    logic [7:0] resp_byte = 8'h00;

    int   stretch_left = 0;
    logic stretch_arm = 1'b0;

    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    int          rises = 0;
    int          n_start = 0;
    int          n_stop = 0;
    logic [63:0] bits = '0;

    assign sda_i = sda_o & resp_sda;
    assign scl_i = scl_o & ~(stretch_left > 0);

    always #5 clk = ~clk;

    i2c_master_byte #(.CLK_DIV(C)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .addr    (addr),
        .rw      (rw),
        .wdata   (wdata),
        .scl_i   (scl_i),
        .sda_i   (sda_i),
        .scl_o   (scl_o),
        .sda_o   (sda_o),
        .rdata   (rdata),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err)
    );

    function automatic logic resp_value(input int k);
        if (k == 9) return resp_ack ? 1'b0 : 1'b1;
        if (resp_read && k >= 10 && k <= 17) return resp_byte[17 - k];
        if (!resp_read && k == 18) return resp_ack ? 1'b0 : 1'b1;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_scl <= scl_o;
        prev_sda <= sda_o;
        if (stretch_arm) stretch_left <= 50;
        else if (scl_o && stretch_left > 0) stretch_left <= stretch_left - 1;
        if (reset) begin
            resp_sda <= 1'b1;
        end else begin
            if (prev_scl && scl_o && prev_sda && !sda_o) begin
                n_start  <= n_start + 1;
                rises    <= 0;
                resp_sda <= 1'b1;
            end
            if (prev_scl && scl_o && !prev_sda && sda_o) n_stop <= n_stop + 1;
            if (!prev_scl && scl_o) begin
                rises <= rises + 1;
                if (rises < 62) bits[rises + 1] <= sda_i;
            end
            if (prev_scl && !scl_o) resp_sda <= resp_value(rises + 1);
        end
    end

    function automatic logic [7:0] get_byte(input int first);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], bits[first + i]};
        return b;
    endfunction

    task automatic do_start(input logic [6:0] a, input logic r, input logic [7:0] d);
        @(negedge clk);
        addr  = a;
        rw    = r;
        wdata = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_done(input int budget, output int k);
        k = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                k = cyc - t0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (scl_o !== 1'b1) begin failures++; $display("FAIL reset_scl: got %b expected 1", scl_o); end
        checks++; if (sda_o !== 1'b1) begin failures++; $display("FAIL reset_sda: got %b expected 1", sda_o); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL reset_ack_err: got %b expected 0", ack_err); end
        checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_write();
        int k, s0, p0;
        resp_ack = 1'b1; resp_read = 1'b0;
        s0 = n_start; p0 = n_stop;
        do_start(7'h4A, 1'b0, 8'hA5);
        wait_done(2000, k);
        checks++; if (k != 77 * C) begin failures++; $display("FAIL wr_done_cycle: got %0d expected %0d", k, 77 * C); end
        checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL wr_ack_err: got %b expected 0", ack_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_at_done: got %b expected 0", busy); end
        checks++; if (get_byte(1) !== 8'h94) begin failures++; $display("FAIL wr_addr_byte: got %h expected 94", get_byte(1)); end
        checks++; if (bits[9] !== 1'b0) begin failures++; $display("FAIL wr_addr_ack: got %b expected 0", bits[9]); end
        checks++; if (get_byte(10) !== 8'hA5) begin failures++; $display("FAIL wr_data_byte: got %h expected a5", get_byte(10)); end
        checks++; if (bits[18] !== 1'b0) begin failures++; $display("FAIL wr_data_ack: got %b expected 0", bits[18]); end
        checks++; if (rises != 19) begin failures++; $display("FAIL wr_scl_rises: got %0d expected 19", rises); end
        checks++; if (n_start - s0 != 1) begin failures++; $display("FAIL wr_starts: got %0d expected 1", n_start - s0); end
        checks++; if (n_stop - p0 != 1) begin failures++; $display("FAIL wr_stops: got %0d expected 1", n_stop - p0); end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_addr_nack();
        int k;
        resp_ack = 1'b0; resp_read = 1'b0;
        do_start(7'h11, 1'b0, 8'h5A);
        wait_done(2000, k);
        checks++; if (k != 41 * C) begin failures++; $display("FAIL nack_done_cycle: got %0d expected %0d", k, 41 * C); end
        checks++; if (ack_err !== 1'b1) begin failures++; $display("FAIL nack_ack_err: got %b expected 1", ack_err); end
        checks++; if (get_byte(1) !== 8'h22) begin failures++; $display("FAIL nack_addr_byte: got %h expected 22", get_byte(1)); end
        checks++; if (bits[9] !== 1'b1) begin failures++; $display("FAIL nack_ack_bit: got %b expected 1", bits[9]); end
        checks++; if (rises != 10) begin failures++; $display("FAIL nack_scl_rises: got %0d expected 10", rises); end
        repeat (3) @(posedge clk);
        checks++; if (ack_err !== 1'b1) begin failures++; $display("FAIL nack_ack_err_held: got %b expected 1", ack_err); end
    endtask

    task automatic test_read();
        int k;
        resp_ack = 1'b1; resp_read = 1'b1; resp_byte = 8'h3C;
        do_start(7'h4A, 1'b1, 8'h00);
        checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL rd_ack_err_cleared: got %b expected 0", ack_err); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rd_busy_after_start: got %b expected 1", busy); end
        wait_done(2000, k);
        checks++; if (k != 77 * C) begin failures++; $display("FAIL rd_done_cycle: got %0d expected %0d", k, 77 * C); end
        checks++; if (rdata !== 8'h3C) begin failures++; $display("FAIL rd_rdata: got %h expected 3c", rdata); end
        checks++; if (get_byte(1) !== 8'h95) begin failures++; $display("FAIL rd_addr_byte: got %h expected 95", get_byte(1)); end
        checks++; if (get_byte(10) !== 8'h3C) begin failures++; $display("FAIL rd_bus_byte: got %h expected 3c", get_byte(10)); end
        checks++; if (bits[18] !== 1'b1) begin failures++; $display("FAIL rd_nack_bit: got %b expected 1", bits[18]); end
        checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL rd_ack_err: got %b expected 0", ack_err); end
        resp_read = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_stretch();
        int k;
        resp_ack = 1'b1; resp_read = 1'b0;
        do_start(7'h4A, 1'b0, 8'hA5);
        // Arm during the SCL-low half of address bit 3 so the stretch covers its high half
        repeat (61) @(posedge clk);
        @(negedge clk);
        stretch_arm = 1'b1;
        @(negedge clk);
        stretch_arm = 1'b0;
        wait_done(2000, k);
        checks++; if (k != 77 * C + 50) begin failures++; $display("FAIL stretch_done_cycle: got %0d expected %0d", k, 77 * C + 50); end
        checks++; if (get_byte(1) !== 8'h94) begin failures++; $display("FAIL stretch_addr_byte: got %h expected 94", get_byte(1)); end
        checks++; if (get_byte(10) !== 8'hA5) begin failures++; $display("FAIL stretch_data_byte: got %h expected a5", get_byte(10)); end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        int k, s0;
        resp_ack = 1'b1; resp_read = 1'b0;
        s0 = n_start;
        do_start(7'h4A, 1'b0, 8'hA5);
        repeat (20) @(posedge clk);
        @(negedge clk);
        addr = 7'h11; wdata = 8'h00; rw = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        wait_done(2000, k);
        checks++; if (k != 77 * C) begin failures++; $display("FAIL b2b_done_cycle: got %0d expected %0d", k, 77 * C); end
        checks++; if (get_byte(1) !== 8'h94) begin failures++; $display("FAIL b2b_addr_byte: got %h expected 94", get_byte(1)); end
        checks++; if (get_byte(10) !== 8'hA5) begin failures++; $display("FAIL b2b_data_byte: got %h expected a5", get_byte(10)); end
        repeat (40) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_after: got %b expected 0", busy); end
        checks++; if (n_start - s0 != 1) begin failures++; $display("FAIL b2b_starts: got %0d expected 1", n_start - s0); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        resp_ack = 1'b1; resp_read = 1'b0;
        do_start(7'h4A, 1'b0, 8'hA5);
        repeat (200) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (scl_o !== 1'b1) begin failures++; $display("FAIL rst_mid_scl: got %b expected 1", scl_o); end
        checks++; if (sda_o !== 1'b1) begin failures++; $display("FAIL rst_mid_sda: got %b expected 1", sda_o); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_no_done: got %b expected 0", seen); end
        test_write();
    endtask

    initial begin
        test_reset();
        test_write();
        test_addr_nack();
        test_read();
        test_stretch();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
